// File: rtl/bus_router.sv
`default_nettype none

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef BUS_ACC_RSV
`define BUS_ACC_RSV 2'd3
`endif

// ============================================================================
// Module      : bus_router
// Description : Single-master request router. Decodes the master address
//               against NS slave windows, forwards the request with a
//               window-relative offset, waits for the selected slave's
//               response and returns registered rdata/fault. Faults are
//               generated for unmapped, misaligned, reserved-size and
//               timed-out accesses; the last fault cause/address is kept.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               m_*                 - master request / response side
//               s_*                 - slave request / response side (NS ports)
//               fault_cause/addr    - sticky record of the last fault
// Revision    : 1.0 - initial release
// ============================================================================
module bus_router #(
    parameter int                NS      = 4,
    parameter logic [32*NS-1:0]  S_BASE  = {32'h3000_0000, 32'h2000_0000,
                                            32'h1000_0000, 32'h0000_0000},
    parameter logic [8*NS-1:0]   S_AW    = {8'd3, 8'd19, 8'd12, 8'd12},
    parameter int                TIMEOUT = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              m_req,
    input  logic [31:0]                       m_addr,
    input  logic                              m_wr_b,
    input  logic [$clog2(`BUS_ACC_CNT)-1:0]   m_acc,
    input  logic [`BUS_WIDTH-1:0]             m_wdata,
    output logic                              m_resp,
    output logic [`BUS_WIDTH-1:0]             m_rdata,
    output logic                              m_fault,
    output logic [NS-1:0]                     s_req,
    output logic [31:0]                       s_addr,
    output logic                              s_wr_b,
    output logic [$clog2(`BUS_ACC_CNT)-1:0]   s_acc,
    output logic [`BUS_WIDTH-1:0]             s_wdata,
    input  logic [NS*`BUS_WIDTH-1:0]          s_rdata,
    input  logic [NS-1:0]                     s_resp,
    input  logic [NS-1:0]                     s_fault,
    output logic [1:0]                        fault_cause,
    output logic [31:0]                       fault_addr
);

    localparam int C_SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int C_BW = `BUS_WIDTH;

    localparam logic [1:0] C_CAUSE_NONE  = 2'd0;
    localparam logic [1:0] C_CAUSE_UNMAP = 2'd1;
    localparam logic [1:0] C_CAUSE_ALIGN = 2'd2;
    localparam logic [1:0] C_CAUSE_SLAVE = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [C_SW-1:0]   r_sel;
    logic              r_pend_fault;
    logic              r_wr_b;
    logic [31:0]       r_addr;
    logic [31:0]       r_count;

    logic              w_hit_any;
    logic [C_SW-1:0]   w_sel;
    logic [31:0]       w_mask;
    logic              w_misaligned;
    logic              w_rsv;
    logic              w_bad;
    logic [1:0]        w_cause;
    logic              w_accept;
    logic              w_expired;

    // Address decode. Iterating from the top index down lets the lowest
    // matching window overwrite any higher one.
    always_comb begin
        w_hit_any = 1'b0;
        w_sel     = '0;
        w_mask    = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((m_addr >> S_AW[8*i +: 8]) == (S_BASE[32*i +: 32] >> S_AW[8*i +: 8])) begin
                w_hit_any = 1'b1;
                w_sel     = C_SW'(i);
                w_mask    = 32'((33'd1 << S_AW[8*i +: 8]) - 33'd1);
            end
        end
    end

    // Pre-checks: reserved size, then alignment, then unmapped.
    always_comb begin
        w_rsv        = (m_acc == `BUS_ACC_RSV);
        w_misaligned = ((m_acc == `BUS_ACC_2B) && m_addr[0]) ||
                       ((m_acc == `BUS_ACC_4B) && (m_addr[1:0] != 2'b00));
        w_cause      = C_CAUSE_NONE;
        if (w_rsv || w_misaligned) begin
            w_cause = C_CAUSE_ALIGN;
        end else if (!w_hit_any) begin
            w_cause = C_CAUSE_UNMAP;
        end
        w_bad = (w_cause != C_CAUSE_NONE);
    end

    assign w_accept  = !rst && (r_state == ST_IDLE) && m_req && !w_bad;
    assign w_expired = (TIMEOUT != 0) && (r_count == 32'(TIMEOUT - 1));

    // Request path is purely combinational so the slave sees the request in
    // the same cycle as the master.
    assign s_req   = w_accept ? (NS'(1) << w_sel) : '0;
    assign s_addr  = m_addr & w_mask;
    assign s_wr_b  = m_wr_b;
    assign s_acc   = m_acc;
    assign s_wdata = m_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_pend_fault <= 1'b0;
            r_wr_b       <= 1'b0;
            r_addr       <= '0;
            r_count      <= '0;
            m_resp       <= 1'b0;
            m_rdata      <= '0;
            m_fault      <= 1'b0;
            fault_cause  <= C_CAUSE_NONE;
            fault_addr   <= '0;
        end else begin
            m_resp <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (m_req) begin
                        if (w_bad) begin
                            m_resp      <= 1'b1;
                            m_fault     <= 1'b1;
                            m_rdata     <= '0;
                            fault_cause <= w_cause;
                            fault_addr  <= m_addr;
                        end else begin
                            // Slave fault is only valid in the request cycle,
                            // so hold it until the slave completes.
                            r_sel        <= w_sel;
                            r_pend_fault <= s_fault[w_sel];
                            r_wr_b       <= m_wr_b;
                            r_addr       <= m_addr;
                            r_count      <= '0;
                            r_state      <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (s_resp[r_sel]) begin
                        m_resp  <= 1'b1;
                        m_rdata <= r_wr_b ? '0 : s_rdata[C_BW*r_sel +: C_BW];
                        m_fault <= r_pend_fault;
                        if (r_pend_fault) begin
                            fault_cause <= C_CAUSE_SLAVE;
                            fault_addr  <= r_addr;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_expired) begin
                        m_resp      <= 1'b1;
                        m_fault     <= 1'b1;
                        m_rdata     <= '0;
                        fault_cause <= C_CAUSE_SLAVE;
                        fault_addr  <= r_addr;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 32'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_router.sv
`default_nettype none

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef BUS_ACC_RSV
`define BUS_ACC_RSV 2'd3
`endif

// ============================================================================
// Module      : tb_bus_router
// Description : Directed self-checking bench for bus_router.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_router;

    logic         clk;
    logic         rst;
    logic         m_req;
    logic [31:0]  m_addr;
    logic         m_wr_b;
    logic [1:0]   m_acc;
    logic [31:0]  m_wdata;
    logic         m_resp;
    logic [31:0]  m_rdata;
    logic         m_fault;
    logic [3:0]   s_req;
    logic [31:0]  s_addr;
    logic         s_wr_b;
    logic [1:0]   s_acc;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;
    logic [3:0]   s_resp;
    logic [3:0]   s_fault;
    logic [1:0]   fault_cause;
    logic [31:0]  fault_addr;

    int total = 0;
    int bad   = 0;

    bus_router dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_wr_b(m_wr_b), .m_acc(m_acc),
        .m_wdata(m_wdata), .m_resp(m_resp), .m_rdata(m_rdata), .m_fault(m_fault),
        .s_req(s_req), .s_addr(s_addr), .s_wr_b(s_wr_b), .s_acc(s_acc),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault),
        .fault_cause(fault_cause), .fault_addr(fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_req = 1'b1; m_addr = 32'h1000_0010; m_acc = `BUS_ACC_4B;
        #1;
        total++;
        if (s_req !== 4'b0000) begin
            bad++; $display("FAIL reset_sreq: got %b want %b", s_req, 4'b0000);
        end
        tick(); tick();
        total++;
        if (m_resp !== 1'b0 || m_fault !== 1'b0 || m_rdata !== 32'h0 ||
            fault_cause !== 2'd0 || fault_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got resp=%b fault=%b rdata=%h cause=%0d faddr=%h want all 0",
                     m_resp, m_fault, m_rdata, fault_cause, fault_addr);
        end
        m_req = 1'b0;
        rst   = 1'b0;
        tick();
    endtask

    task automatic test_read();
        // cycle 0
        m_req = 1'b1; m_addr = 32'h1000_0010; m_wr_b = 1'b0; m_acc = `BUS_ACC_4B;
        #1;
        total++;
        if (s_req !== 4'b0010 || s_addr !== 32'h0000_0010) begin
            bad++; $display("FAIL read_req: got s_req=%b s_addr=%h want 0010 00000010", s_req, s_addr);
        end
        tick();
        // cycle 1
        m_req = 1'b0;
        s_resp = 4'b0010; s_rdata[63:32] = 32'hDEAD_BEEF;
        total++;
        if (m_resp !== 1'b0) begin
            bad++; $display("FAIL read_early: got m_resp=%b want 0", m_resp);
        end
        tick();
        // cycle 2
        s_resp = 4'b0000;
        total++;
        if (m_resp !== 1'b1 || m_rdata !== 32'hDEAD_BEEF || m_fault !== 1'b0) begin
            bad++; $display("FAIL read_resp: got resp=%b rdata=%h fault=%b want 1 deadbeef 0",
                            m_resp, m_rdata, m_fault);
        end
        tick();
        total++;
        if (m_resp !== 1'b0 || m_rdata !== 32'hDEAD_BEEF || fault_cause !== 2'd0) begin
            bad++; $display("FAIL read_hold: got resp=%b rdata=%h cause=%0d want 0 deadbeef 0",
                            m_resp, m_rdata, fault_cause);
        end
    endtask

    task automatic test_unmapped();
        m_req = 1'b1; m_addr = 32'h4000_0000; m_acc = `BUS_ACC_4B; m_wr_b = 1'b0;
        #1;
        total++;
        if (s_req !== 4'b0000) begin
            bad++; $display("FAIL unmap_sreq: got %b want 0000", s_req);
        end
        tick();
        m_req = 1'b0;
        total++;
        if (m_resp !== 1'b1 || m_fault !== 1'b1 || m_rdata !== 32'h0 ||
            fault_cause !== 2'd1 || fault_addr !== 32'h4000_0000) begin
            bad++; $display("FAIL unmap_resp: got resp=%b fault=%b rdata=%h cause=%0d faddr=%h want 1 1 0 1 40000000",
                            m_resp, m_fault, m_rdata, fault_cause, fault_addr);
        end
        tick();
    endtask

    task automatic test_precheck();
        logic [31:0] addrs [3];
        logic [1:0]  accs  [3];
        addrs[0] = 32'h0000_0002; accs[0] = `BUS_ACC_4B;
        addrs[1] = 32'h0000_0001; accs[1] = `BUS_ACC_2B;
        addrs[2] = 32'h1000_0000; accs[2] = `BUS_ACC_RSV;
        for (int k = 0; k < 3; k++) begin
            m_req = 1'b1; m_addr = addrs[k]; m_acc = accs[k];
            #1;
            total++;
            if (s_req !== 4'b0000) begin
                bad++; $display("FAIL precheck_sreq[%0d]: got %b want 0000", k, s_req);
            end
            tick();
            m_req = 1'b0;
            total++;
            if (m_resp !== 1'b1 || m_fault !== 1'b1 || fault_cause !== 2'd2 ||
                fault_addr !== addrs[k]) begin
                bad++; $display("FAIL precheck_resp[%0d]: got resp=%b fault=%b cause=%0d faddr=%h want 1 1 2 %h",
                                k, m_resp, m_fault, fault_cause, fault_addr, addrs[k]);
            end
            tick();
        end
    endtask

    task automatic test_slave_fault();
        m_req = 1'b1; m_addr = 32'h0000_0100; m_wr_b = 1'b1; m_acc = `BUS_ACC_4B;
        m_wdata = 32'hCAFE_0001; s_fault = 4'b0001;
        #1;
        total++;
        if (s_req !== 4'b0001 || s_addr !== 32'h100 || s_wr_b !== 1'b1 ||
            s_wdata !== 32'hCAFE_0001 || s_acc !== `BUS_ACC_4B) begin
            bad++; $display("FAIL sfault_req: got s_req=%b s_addr=%h wr=%b wdata=%h acc=%0d",
                            s_req, s_addr, s_wr_b, s_wdata, s_acc);
        end
        tick();
        m_req = 1'b0; s_fault = 4'b0000; s_resp = 4'b0001; s_rdata[31:0] = 32'h1234_5678;
        tick();
        s_resp = 4'b0000;
        total++;
        if (m_resp !== 1'b1 || m_fault !== 1'b1 || m_rdata !== 32'h0 ||
            fault_cause !== 2'd3 || fault_addr !== 32'h0000_0100) begin
            bad++; $display("FAIL sfault_resp: got resp=%b fault=%b rdata=%h cause=%0d faddr=%h want 1 1 0 3 00000100",
                            m_resp, m_fault, m_rdata, fault_cause, fault_addr);
        end
        m_wr_b = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        m_req = 1'b1; m_addr = 32'h2000_0040; m_wr_b = 1'b0; m_acc = `BUS_ACC_4B;
        #1;
        total++;
        if (s_req !== 4'b0100 || s_addr !== 32'h40) begin
            bad++; $display("FAIL tmo_req: got s_req=%b s_addr=%h want 0100 00000040", s_req, s_addr);
        end
        tick();
        m_req = 1'b0;
        for (int c = 1; c < 256; c++) begin
            total++;
            if (m_resp !== 1'b0) begin
                bad++; $display("FAIL tmo_early: cycle %0d got m_resp=%b want 0", c, m_resp);
            end
            if (c == 5) begin
                // Request while waiting and a response on another port.
                m_req = 1'b1; m_addr = 32'h1000_0000; s_resp = 4'b0010;
                #1;
                total++;
                if (s_req !== 4'b0000) begin
                    bad++; $display("FAIL tmo_busy_sreq: got %b want 0000", s_req);
                end
            end
            tick();
            m_req = 1'b0; s_resp = 4'b0000;
        end
        // cycle 256
        total++;
        if (m_resp !== 1'b1 || m_fault !== 1'b1 || m_rdata !== 32'h0 ||
            fault_cause !== 2'd3 || fault_addr !== 32'h2000_0040) begin
            bad++; $display("FAIL tmo_resp: got resp=%b fault=%b rdata=%h cause=%0d faddr=%h want 1 1 0 3 20000040",
                            m_resp, m_fault, m_rdata, fault_cause, fault_addr);
        end
        for (int c = 256; c < 300; c++) tick();
        s_resp = 4'b0100;
        tick();
        s_resp = 4'b0000;
        total++;
        if (m_resp !== 1'b0) begin
            bad++; $display("FAIL tmo_stray: got m_resp=%b want 0", m_resp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        m_req = 1'b1; m_addr = 32'h1000_0020; m_wr_b = 1'b0; m_acc = `BUS_ACC_4B;
        tick();
        m_req = 1'b0; s_resp = 4'b0010; s_rdata[63:32] = 32'h1111_2222;
        tick();
        // cycle 2: first m_resp, issue second request now
        s_resp = 4'b0000;
        m_req = 1'b1; m_addr = 32'h3000_0004; m_acc = `BUS_ACC_2B;
        #1;
        total++;
        if (m_resp !== 1'b1 || m_rdata !== 32'h1111_2222 || s_req !== 4'b1000 || s_addr !== 32'h4) begin
            bad++; $display("FAIL b2b_first: got resp=%b rdata=%h s_req=%b s_addr=%h want 1 11112222 1000 00000004",
                            m_resp, m_rdata, s_req, s_addr);
        end
        tick();
        m_req = 1'b0; s_resp = 4'b1000; s_rdata[127:96] = 32'h0000_BEEF;
        tick();
        s_resp = 4'b0000;
        total++;
        if (m_resp !== 1'b1 || m_rdata !== 32'h0000_BEEF || m_fault !== 1'b0) begin
            bad++; $display("FAIL b2b_second: got resp=%b rdata=%h fault=%b want 1 0000beef 0",
                            m_resp, m_rdata, m_fault);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        m_req = 1'b1; m_addr = 32'h2000_0000; m_acc = `BUS_ACC_1B;
        tick();
        m_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (m_resp !== 1'b0 || m_rdata !== 32'h0 || m_fault !== 1'b0 ||
            fault_cause !== 2'd0 || fault_addr !== 32'h0) begin
            bad++; $display("FAIL rstwait_outputs: got resp=%b rdata=%h fault=%b cause=%0d faddr=%h want all 0",
                            m_resp, m_rdata, m_fault, fault_cause, fault_addr);
        end
        s_resp = 4'b0100; s_rdata[95:64] = 32'h5555_AAAA;
        tick();
        s_resp = 4'b0000;
        total++;
        if (m_resp !== 1'b0 || m_rdata !== 32'h0) begin
            bad++; $display("FAIL rstwait_late: got resp=%b rdata=%h want 0 0", m_resp, m_rdata);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; m_req = 1'b0; m_addr = '0; m_wr_b = 1'b0; m_acc = '0;
        m_wdata = '0; s_rdata = '0; s_resp = '0; s_fault = '0;
        test_reset();
        test_read();
        test_unmapped();
        test_precheck();
        test_slave_fault();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_router.md
Name: bus_router

Overview:
- Single-master request router sitting directly upstream of the memory and peripheral controllers (tcm, rom, sram, gpio).
- Accepts one core-side bus transaction at a time and decodes its address against NS slave windows.
- Forwards the request with a window-relative byte offset and waits for the selected slave's resp. Returns registered rdata/fault to the master.
- Also generates faults for unmapped, misaligned and reserved-size accesses and for slave timeouts, and records the cause and address of the last fault.

Parameters:
- NS, 4, number of slave ports.
- S_BASE, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, packed base addresses; slave i uses S_BASE[32*i+:32]; each base is aligned to its window size.
- S_AW, {8'd3, 8'd19, 8'd12, 8'd12}, packed window byte-address widths; slave i uses S_AW[8*i+:8]; window size is 1<<S_AW.
- TIMEOUT, 255, max cycles spent in WAIT before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m_req  in  1  master request pulse, one cycle
- m_addr  in  32  master byte address
- m_wr_b  in  1  1=write, 0=read
- m_acc  in  $clog2(`BUS_ACC_CNT)  access size code (`BUS_ACC_1B/2B/4B/RSV)
- m_wdata  in  `BUS_WIDTH  write data
- m_resp  out  1  one-cycle completion pulse
- m_rdata  out  `BUS_WIDTH  read data, valid with m_resp
- m_fault  out  1  transaction faulted, valid with m_resp
- s_req  out  NS  one-hot slave request pulse
- s_addr  out  32  window offset (m_addr & ((1<<S_AW[i])-1)); integration truncates per slave
- s_wr_b  out  1  forwarded m_wr_b
- s_acc  out  $clog2(`BUS_ACC_CNT)  forwarded m_acc
- s_wdata  out  `BUS_WIDTH  forwarded m_wdata
- s_rdata  in  NS*`BUS_WIDTH  slave i read data at [`BUS_WIDTH*i+:`BUS_WIDTH]
- s_resp  in  NS  slave completion pulses
- s_fault  in  NS  slave fault, combinational, valid in the request cycle
- fault_cause  out  2  last fault: 0 none, 1 unmapped, 2 misaligned/RSV, 3 timeout or slave fault
- fault_addr  out  32  m_addr of the last faulting transaction

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; m_resp=0, m_rdata=0, m_fault=0, fault_cause=0, fault_addr=0, timeout count=0.
  - s_req is forced 0 combinationally while rst=1.
  - Reset in WAIT abandons the transaction with no m_resp. A slave resp arriving later is ignored.
- Decode (combinational on m_addr):
  - hit_i = (m_addr >> S_AW[i]) == (S_BASE[32*i+:32] >> S_AW[i]).
  - When several windows hit, the lowest index wins.
- Pre-checks (combinational), in priority order:
  - RSV: m_acc==`BUS_ACC_RSV -> cause 2.
  - Misaligned: 2B with addr[0]!=0, or 4B with addr[1:0]!=0 -> cause 2.
  - Unmapped: no hit -> cause 1.
- s_addr, s_wr_b, s_acc and s_wdata are combinational pass-through. s_req is combinational from m_req (zero added request latency).
- FSM state IDLE:
  - m_req with a pre-check failure: no s_req. Next cycle m_resp=1, m_fault=1, m_rdata=0; fault_cause and fault_addr are updated; state stays IDLE.
  - m_req that passes the pre-checks: s_req[sel]=1 this cycle. Latch sel, latch pend_fault=s_fault[sel] and latch m_addr; go to WAIT with count=0.
  - s_resp while in IDLE is ignored.
- FSM state WAIT:
  - m_req is ignored (no s_req, no state change); the master must wait for m_resp.
  - s_resp[sel]=1: next cycle m_resp=1, m_rdata = wr_b ? 0 : s_rdata[sel], m_fault=pend_fault; state returns to IDLE. If pend_fault=1, fault_cause=3 and fault_addr=latched addr.
  - s_resp on non-selected ports is ignored.
  - Otherwise count increments. If TIMEOUT!=0 and count==TIMEOUT-1 with no s_resp: next cycle m_resp=1, m_fault=1, m_rdata=0, fault_cause=3; state returns to IDLE.
  - s_resp[sel] in the same cycle as expiry takes priority (normal completion).
- m_resp, m_rdata and m_fault are registered. m_resp is high for exactly one cycle; m_rdata and m_fault hold their values until the next m_resp.
- Latency, measured from m_req in cycle 0:
  - 1-cycle slave (s_resp in cycle 1): m_resp in cycle 2.
  - Pre-check fault: m_resp in cycle 1.
- Back-to-back: state is already IDLE in the m_resp cycle, so a new m_req in that cycle is accepted.
- fault_cause and fault_addr are sticky until the next fault or reset.

Test Plan:
- Read 4B at 0x1000_0010, slave1 returns s_resp in cycle 1 with 0xDEADBEEF -> s_req=4'b0010, s_addr=0x010 in cycle 0; m_resp=1, m_rdata=0xDEADBEEF, m_fault=0 in cycle 2.
- m_req to 0x4000_0000 -> no s_req; m_resp and m_fault in cycle 1; fault_cause=1, fault_addr=0x4000_0000.
- 4B access to 0x0000_0002, then 2B to 0x0000_0001, then acc=RSV -> each gets m_fault one cycle later with cause 2 and no s_req.
- Write to ROM window with slave0 s_fault=1 in the request cycle and s_resp in cycle 1 -> m_resp and m_fault in cycle 2, cause 3.
- Slave2 never responds, TIMEOUT=255 -> m_resp and m_fault in cycle 256, cause 3; a stray s_resp[2] in cycle 300 -> no m_resp.
- Back-to-back reads to slaves 1 then 3 issued in the m_resp cycle of the first -> both complete, second m_resp 2 cycles later. Assert rst during WAIT -> no m_resp, all outputs 0.
